vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised VGA raster timing generator; successor to the fixed 640x480 sync block.
//  Runs on the system clock, advanced by a pixel-enable tick (pix_en), so no derived clocks are needed.
//  Adds the following over the fixed block:
//   - configurable porches, sync widths and sync polarity;
//   - a sync/blank delay line that aligns timing with the colour pipeline;
//   - line and frame strobes, and a frame counter.
//  Sits between the clock divider/tick source and the colour controller.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch (ticks)
//  H_SYNC    96   hsync pulse width (ticks)
//  H_BP      48   horizontal back porch (ticks)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch (lines)
//  V_SYNC    2    vsync pulse width (lines)
//  V_BP      33   vertical back porch (lines)
//  H_POL     0    hsync active level (0 = active-low)
//  V_POL     0    vsync active level (0 = active-low)
//  PIPE_DLY  1    pix_en ticks of delay on hsync/vsync/video_on; legal range 1..8
//  CNT_W     10   pixel_x/pixel_y width; must hold H_TOTAL-1 and V_TOTAL-1
//  FRAME_W   8    frame counter width
// PORTS
//  clk          in   1        system clock
//  reset_n      in   1        asynchronous reset, active-low
//  pix_en       in   1        pixel tick; all timing state advances only on clk edges where pix_en=1
//  pixel_x      out  CNT_W    current horizontal position h_cnt
//  pixel_y      out  CNT_W    current vertical position v_cnt
//  hsync        out  1        horizontal sync, delayed PIPE_DLY ticks
//  vsync        out  1        vertical sync, delayed PIPE_DLY ticks
//  video_on     out  1        active-area flag, delayed PIPE_DLY ticks
//  line_start   out  1        1-clk pulse: h_cnt becomes 0 on an active line
//  frame_start  out  1        1-clk pulse: (h_cnt,v_cnt) becomes (0,0)
//  frame_cnt    out  FRAME_W  completed-frame count, wraps modulo 2^FRAME_W
// BEHAVIOUR
//  - Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Default is 800x525.
//  - Counters, on a clk edge with pix_en=1:
//     h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments;
//     v_cnt wraps to 0 at V_TOTAL-1, and only when h_cnt also wraps.
//     With pix_en=0 every register holds its value, including the delay line.
//  - Decode of position (h,v):
//     hs_raw = (H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC)
//     vs_raw = (V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC)
//     vid_raw = (h < H_ACTIVE) && (v < V_ACTIVE)
//  - Delay line: PIPE_DLY register stages, shifted on pix_en.
//     Decode of position P appears on the outputs while pixel_x/pixel_y present position P+PIPE_DLY,
//     with raster wrap.
//     hsync = hs_raw_d ? H_POL : ~H_POL; vsync likewise with V_POL. All three outputs are registered.
//  - Strobes are registered and high for exactly one clk.
//     Each is asserted on the clk after the pix_en edge that loads the corresponding position.
//     line_start: new h_cnt=0 with new v_cnt<V_ACTIVE.
//     frame_start: new (0,0).
//     frame_cnt increments on that same pix_en edge.
//     No strobe fires on reset release; the first frame_start follows the first full frame.
//  - Reset (reset_n=0, asynchronous, overrides pix_en), applied immediately:
//     h_cnt=v_cnt=0; every delay stage = inactive (no sync, video_on=0);
//     hsync=~H_POL, vsync=~V_POL, video_on=0; line_start=frame_start=0; frame_cnt=0.
//     Reset mid-frame/mid-sync: outputs drop to idle at once; counting restarts at (0,0) on the first pix_en after release.
//  - pix_en may be any duty cycle, including 1 every clk and irregular; timing is counted in ticks, never in clks.
//  - Illegal parameter combinations are rejected at elaboration:
//     PIPE_DLY outside 1..8; CNT_W too narrow; any zero-width sync.
// TESTING
//  T1 defaults, pix_en=1 every clk:
//     hsync low exactly 96 clks per line, falling while pixel_x=657;
//     line period 800 clks; frame 420000 clks; 307200 video_on clks per frame.
//  T2 defaults, pix_en 1-in-4 clks:
//     counters and outputs hold between ticks; frame = 1680000 clks; hsync width = 384 clks.
//  T3 H=4/1/1/1, V=3/1/1/1, H_POL=V_POL=1, PIPE_DLY=3, random pix_en:
//     cycle-exact match against a reference model over 5 frames.
//  T4 FRAME_W=2, 5 frames:
//     frame_start exactly 1 clk per frame; frame_cnt 1,2,3,0,1.
//     line_start count per frame = V_ACTIVE (480).
//  T5 reset_n pulsed low during vsync, asynchronous to clk:
//     hsync=vsync=1 and video_on=0 with no clk edge; pixel_x=pixel_y=0;
//     first frame_start after release falls exactly 420000 ticks later.
//  T6 pix_en held 0 for 1000 clks mid-line:
//     no output or counter changes; resumes at the same position.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator advanced by a pixel-enable tick.
// The counters give the current raster position. Sync and video flags are decoded from that position.
// The decoded flags pass through a delay line so that they line up with the colour pipeline.
// Line and frame strobes pulse for one clk, and a frame counter counts completed frames.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter bit          H_POL    = 1'b0,
   parameter bit          V_POL    = 1'b0,
   parameter int unsigned PIPE_DLY = 1,
   parameter int unsigned CNT_W    = 10,
   parameter int unsigned FRAME_W  = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               pix_en,
   output logic [CNT_W-1:0]   pixel_x,
   output logic [CNT_W-1:0]   pixel_y,
   output logic               hsync,
   output logic               vsync,
   output logic               video_on,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   // Reject parameter sets that cannot produce a valid raster
   if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_bad_dly
      $error("vga_timing_gen: PIPE_DLY must be in 1..8");
   end
   if (((H_TOTAL - 1) >> CNT_W) != 0 || ((V_TOTAL - 1) >> CNT_W) != 0) begin : g_bad_cnt_w
      $error("vga_timing_gen: CNT_W too narrow for the raster totals");
   end
   if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
      $error("vga_timing_gen: sync widths must be non-zero");
   end

   logic [CNT_W-1:0]   r_h_cnt;
   logic [CNT_W-1:0]   r_v_cnt;
   logic               r_hsync;
   logic               r_vsync;
   logic               r_video_on;
   logic               r_line_start;
   logic               r_frame_start;
   logic [FRAME_W-1:0] r_frame_cnt;

   logic               w_h_wrap;
   logic               w_v_wrap;
   logic [CNT_W-1:0]   w_h_next;
   logic [CNT_W-1:0]   w_v_next;
   logic [2:0]         w_raw;   // {hs, vs, vid} decoded at the current position
   logic [2:0]         w_tail;  // decode entering the output register

   // Next raster position, wrapping h at line end and v at frame end
   always_comb begin
      w_h_wrap = (r_h_cnt == H_LAST);
      w_v_wrap = (r_v_cnt == V_LAST);
      w_h_next = r_h_cnt + CNT_W'(1);
      w_v_next = r_v_cnt;
      if (w_h_wrap) begin
         w_h_next = '0;
         w_v_next = w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
      end
   end

   // Active-high sync and video decode of the current position
   always_comb begin
      w_raw    = 3'b000;
      w_raw[2] = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
      w_raw[1] = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
      w_raw[0] = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   end

   // PIPE_DLY-1 raw stages; the output register provides the final stage
   if (PIPE_DLY == 1) begin : g_dly_none
      assign w_tail = w_raw;
   end else begin : g_dly
      localparam int N_STG = int'(PIPE_DLY) - 1;
      logic [2:0] r_stage [N_STG];

      // Shift the decoded flags one stage per pixel tick
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int i = 0; i < N_STG; i++) r_stage[i] <= 3'b000;
         end else if (pix_en) begin
            r_stage[0] <= w_raw;
            for (int i = 1; i < N_STG; i++) r_stage[i] <= r_stage[i-1];
         end
      end

      assign w_tail = r_stage[N_STG-1];
   end

   // Counters, polarity-applied outputs, strobes and frame count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_h_cnt       <= '0;
         r_v_cnt       <= '0;
         r_hsync       <= ~H_POL;
         r_vsync       <= ~V_POL;
         r_video_on    <= 1'b0;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_cnt   <= '0;
      end else begin
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
         if (pix_en) begin
            r_h_cnt       <= w_h_next;
            r_v_cnt       <= w_v_next;
            r_hsync       <= w_tail[2] ? H_POL : ~H_POL;
            r_vsync       <= w_tail[1] ? V_POL : ~V_POL;
            r_video_on    <= w_tail[0];
            r_line_start  <= w_h_wrap && (w_v_next < V_ACT);
            r_frame_start <= w_h_wrap && w_v_wrap;
            if (w_h_wrap && w_v_wrap) r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
         end
      end
   end

   assign pixel_x     = r_h_cnt;
   assign pixel_y     = r_v_cnt;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x525 instance and a tiny 7x6 instance.
// The reference model derives every output from the number of pixel ticks since reset.
module tb_vga_timing_gen;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       vid;
      logic       ls;
      logic       fs;
      logic [7:0] fc;
   } obs_t;

   typedef struct packed {
      int ha; int hf; int hs; int hb;
      int va; int vf; int vs; int vb;
      bit hp; bit vp;
      int dly; int fw;
   } cfg_t;

   localparam cfg_t C_DEF = '{ha:640, hf:16, hs:96, hb:48, va:480, vf:10, vs:2, vb:33,
                              hp:1'b0, vp:1'b0, dly:1, fw:8};
   localparam cfg_t C_SML = '{ha:4, hf:1, hs:1, hb:1, va:3, vf:1, vs:1, vb:1,
                              hp:1'b1, vp:1'b1, dly:3, fw:2};

   int checks   = 0;
   int failures = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Default instance
   logic       d_rst_n = 1'b1;
   logic       d_pix_en = 1'b0;
   logic [9:0] d_x, d_y;
   logic       d_hs, d_vs, d_vid, d_ls, d_fs;
   logic [7:0] d_fc;

   vga_timing_gen u_def (
      .clk(clk), .reset_n(d_rst_n), .pix_en(d_pix_en),
      .pixel_x(d_x), .pixel_y(d_y), .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
      .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
   );

   // Small instance: H=4/1/1/1, V=3/1/1/1, active-high syncs, 3-tick delay, 2-bit frame count
   logic       s_rst_n = 1'b1;
   logic       s_pix_en = 1'b0;
   logic [9:0] s_x, s_y;
   logic       s_hs, s_vs, s_vid, s_ls, s_fs;
   logic [1:0] s_fc;

   vga_timing_gen #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(3), .CNT_W(10), .FRAME_W(2)
   ) u_small (
      .clk(clk), .reset_n(s_rst_n), .pix_en(s_pix_en),
      .pixel_x(s_x), .pixel_y(s_y), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
      .line_start(s_ls), .frame_start(s_fs), .frame_cnt(s_fc)
   );

   obs_t d_obs, s_obs;
   assign d_obs = {d_x, d_y, d_hs, d_vs, d_vid, d_ls, d_fs, d_fc};
   assign s_obs = {s_x, s_y, s_hs, s_vs, s_vid, s_ls, s_fs, 6'b0, s_fc};

   // Tick counters since reset, plus whether the last clk edge was a tick
   longint d_t = 0, s_t = 0;
   bit     d_tick = 1'b0, s_tick = 1'b0;

   always @(posedge clk or negedge d_rst_n)
      if (!d_rst_n) begin d_t <= 0; d_tick <= 1'b0; end
      else begin d_t <= d_t + longint'(d_pix_en); d_tick <= d_pix_en; end

   always @(posedge clk or negedge s_rst_n)
      if (!s_rst_n) begin s_t <= 0; s_tick <= 1'b0; end
      else begin s_t <= s_t + longint'(s_pix_en); s_tick <= s_pix_en; end

   // Expected outputs after t ticks: position t, flags of position t-dly (idle before that)
   function automatic obs_t model(input cfg_t c, input longint t, input bit tick);
      obs_t   o;
      longint ht, vt, ft, p, h, v;
      ht = longint'(c.ha + c.hf + c.hs + c.hb);
      vt = longint'(c.va + c.vf + c.vs + c.vb);
      ft = ht * vt;
      o.x   = 10'(t % ht);
      o.y   = 10'((t / ht) % vt);
      o.hs  = ~c.hp;
      o.vs  = ~c.vp;
      o.vid = 1'b0;
      if (t >= longint'(c.dly)) begin
         p = (t - longint'(c.dly)) % ft;
         h = p % ht;
         v = p / ht;
         if (h >= c.ha + c.hf && h < c.ha + c.hf + c.hs) o.hs = c.hp;
         if (v >= c.va + c.vf && v < c.va + c.vf + c.vs) o.vs = c.vp;
         o.vid = (h < c.ha) && (v < c.va);
      end
      o.ls = tick && (t % ht == 0) && ((t / ht) % vt < c.va);
      o.fs = tick && (t % ft == 0);
      o.fc = 8'((t / ft) % (longint'(1) << c.fw));
      return o;
   endfunction

   task automatic reset_def();
      d_pix_en = 1'b0;
      @(negedge clk); d_rst_n = 1'b0;
      @(negedge clk); @(negedge clk); d_rst_n = 1'b1;
   endtask

   task automatic reset_small();
      s_pix_en = 1'b0;
      @(negedge clk); s_rst_n = 1'b0;
      @(negedge clk); @(negedge clk); s_rst_n = 1'b1;
   endtask

   // Idle outputs under reset, even with pix_en high
   task automatic test_reset();
      d_pix_en = 1'b1; s_pix_en = 1'b1;
      #1; d_rst_n = 1'b0; s_rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (d_obs !== model(C_DEF, d_t, d_tick)) begin
         failures++; $display("FAIL reset_def got=%h exp=%h", d_obs, model(C_DEF, d_t, d_tick));
      end
      checks++;
      if ({d_x, d_y, d_hs, d_vs, d_vid, d_ls, d_fs, d_fc} !== {20'd0, 5'b11000, 8'd0}) begin
         failures++; $display("FAIL reset_def_idle got=%h", d_obs);
      end
      checks++;
      if ({s_x, s_y, s_hs, s_vs, s_vid, s_ls, s_fs, s_fc} !== {20'd0, 5'b00000, 2'd0}) begin
         failures++; $display("FAIL reset_small_idle got=%h", s_obs);
      end
      d_pix_en = 1'b0; s_pix_en = 1'b0;
      d_rst_n = 1'b1; s_rst_n = 1'b1;
   endtask

   // pix_en every clk: hsync width/phase, line period, video_on per line
   task automatic test_full_rate();
      logic prev_hs = 1'b1;
      int low_w = 0, n_fall = 0, n_rise = 0, ls_seen = 0, ls_clk = 0, vid_cnt = 0;
      d_pix_en = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, d_t, d_tick)) begin
            failures++; $display("FAIL full_rate t=%0d got=%h exp=%h", d_t, d_obs, model(C_DEF, d_t, d_tick));
         end
         if (prev_hs && !d_hs) begin
            n_fall++; checks++;
            if (d_x !== 10'd657) begin failures++; $display("FAIL full_rate_hs_fall_x got=%0d exp=657", d_x); end
         end
         if (!d_hs) low_w++;
         if (!prev_hs && d_hs) begin
            n_rise++; checks++;
            if (low_w != 96) begin failures++; $display("FAIL full_rate_hs_width got=%0d exp=96", low_w); end
            low_w = 0;
         end
         prev_hs = d_hs;
         if (d_ls) begin
            if (ls_seen == 1) begin
               checks++;
               if (c - ls_clk != 800) begin failures++; $display("FAIL full_rate_line_period got=%0d exp=800", c - ls_clk); end
               checks++;
               if (vid_cnt != 640) begin failures++; $display("FAIL full_rate_video_clks got=%0d exp=640", vid_cnt); end
            end
            ls_seen++; ls_clk = c; vid_cnt = 0;
         end
         if (d_vid) vid_cnt++;
      end
      checks++;
      if (n_fall != 2 || n_rise != 2 || ls_seen != 2) begin
         failures++; $display("FAIL full_rate_counts got=%0d/%0d/%0d exp=2/2/2", n_fall, n_rise, ls_seen);
      end
   endtask

   // pix_en one clk in four: outputs hold between ticks, hsync stretched to 384 clks
   task automatic test_div4();
      logic prev_hs = 1'b1;
      int low_w = 0, n_rise = 0;
      reset_def();
      for (int c = 0; c < 4000; c++) begin
         d_pix_en = (c % 4 == 0);
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, d_t, d_tick)) begin
            failures++; $display("FAIL div4 t=%0d got=%h exp=%h", d_t, d_obs, model(C_DEF, d_t, d_tick));
         end
         if (prev_hs && !d_hs) begin
            checks++;
            if (d_x !== 10'd657) begin failures++; $display("FAIL div4_hs_fall_x got=%0d exp=657", d_x); end
         end
         if (!d_hs) low_w++;
         if (!prev_hs && d_hs) begin
            n_rise++; checks++;
            if (low_w != 384) begin failures++; $display("FAIL div4_hs_width got=%0d exp=384", low_w); end
            low_w = 0;
         end
         prev_hs = d_hs;
      end
      checks++;
      if (n_rise != 1) begin failures++; $display("FAIL div4_hs_pulses got=%0d exp=1", n_rise); end
   endtask

   // Long pix_en gap mid-line: nothing moves, then counting resumes in place
   task automatic test_pause();
      longint t_hold;
      for (int c = 0; c < 60; c++) begin
         d_pix_en = ($urandom % 2 == 0);
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, d_t, d_tick)) begin
            failures++; $display("FAIL pause_pre t=%0d got=%h exp=%h", d_t, d_obs, model(C_DEF, d_t, d_tick));
         end
      end
      d_pix_en = 1'b0;
      @(negedge clk);
      t_hold = d_t;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, t_hold, 1'b0)) begin
            failures++; $display("FAIL pause_hold c=%0d got=%h exp=%h", c, d_obs, model(C_DEF, t_hold, 1'b0));
         end
      end
      d_pix_en = 1'b1;
      @(negedge clk);
      checks++;
      if (d_x !== 10'((t_hold + 1) % 800)) begin
         failures++; $display("FAIL pause_resume_x got=%0d exp=%0d", d_x, (t_hold + 1) % 800);
      end
      for (int c = 0; c < 200; c++) begin
         d_pix_en = ($urandom % 3 != 0);
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, d_t, d_tick)) begin
            failures++; $display("FAIL pause_post t=%0d got=%h exp=%h", d_t, d_obs, model(C_DEF, d_t, d_tick));
         end
      end
   endtask

   // Asynchronous reset while hsync is asserted on the default instance
   task automatic test_async_reset_hsync();
      bit found = 1'b0;
      reset_def();
      d_pix_en = 1'b1;
      for (int c = 0; c < 2000 && !found; c++) begin
         @(negedge clk);
         if (!d_hs) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL async_def_wait got=timeout exp=hsync_low"); end
      #2 d_rst_n = 1'b0;
      #1;
      checks++;
      if ({d_x, d_y, d_hs, d_vs, d_vid, d_ls, d_fs, d_fc} !== {20'd0, 5'b11000, 8'd0}) begin
         failures++; $display("FAIL async_def_idle got=%h exp=%h", d_obs, {20'd0, 5'b11000, 8'd0});
      end
      #1 d_rst_n = 1'b1;
      for (int c = 0; c < 900; c++) begin
         @(negedge clk);
         checks++;
         if (d_obs !== model(C_DEF, d_t, d_tick)) begin
            failures++; $display("FAIL async_def_post t=%0d got=%h exp=%h", d_t, d_obs, model(C_DEF, d_t, d_tick));
         end
      end
   endtask

   // Random ticks over five small frames: exact model match, frame count, line strobes per frame
   task automatic test_small_random();
      int nfs = 0, ls_cnt = 0;
      reset_small();
      for (int c = 0; c < 3000 && nfs < 5; c++) begin
         s_pix_en = ($urandom % 3 != 0);
         @(negedge clk);
         checks++;
         if (s_obs !== model(C_SML, s_t, s_tick)) begin
            failures++; $display("FAIL small_rand t=%0d got=%h exp=%h", s_t, s_obs, model(C_SML, s_t, s_tick));
         end
         if (s_fs) begin
            if (nfs > 0) begin
               checks++;
               if (ls_cnt != 3) begin failures++; $display("FAIL small_ls_per_frame got=%0d exp=3", ls_cnt); end
            end
            ls_cnt = 0;
            nfs++;
            checks++;
            if (s_fc !== 2'(nfs % 4)) begin
               failures++; $display("FAIL small_frame_cnt got=%0d exp=%0d", s_fc, nfs % 4);
            end
         end
         if (s_ls) ls_cnt++;
      end
      checks++;
      if (nfs != 5) begin failures++; $display("FAIL small_frames got=%0d exp=5", nfs); end
   endtask

   // Asynchronous reset during vsync; first frame_start exactly one frame of ticks later
   task automatic test_small_vsync_reset();
      bit found = 1'b0;
      bit seen  = 1'b0;
      int ticks = 0;
      reset_small();
      for (int c = 0; c < 1000 && !found; c++) begin
         s_pix_en = ($urandom % 2 == 0);
         @(negedge clk);
         if (s_vs) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL small_vsync_wait got=timeout exp=vsync"); end
      #2 s_rst_n = 1'b0;
      #1;
      checks++;
      if ({s_x, s_y, s_hs, s_vs, s_vid, s_ls, s_fs, s_fc} !== {20'd0, 5'b00000, 2'd0}) begin
         failures++; $display("FAIL small_async_idle got=%h", s_obs);
      end
      #1 s_rst_n = 1'b1;
      for (int c = 0; c < 1000 && !seen; c++) begin
         s_pix_en = ($urandom % 2 == 0);
         if (s_pix_en) ticks++;
         @(negedge clk);
         checks++;
         if (s_obs !== model(C_SML, s_t, s_tick)) begin
            failures++; $display("FAIL small_post_rst t=%0d got=%h exp=%h", s_t, s_obs, model(C_SML, s_t, s_tick));
         end
         if (s_fs) seen = 1'b1;
      end
      checks++;
      if (!seen || ticks != 42) begin
         failures++; $display("FAIL small_first_frame ticks got=%0d exp=42 seen=%0d", ticks, seen);
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_div4();
      test_pause();
      test_async_reset_hsync();
      test_small_random();
      test_small_vsync_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
